// File: rtl/nukv_fb_arbiter_if.sv
// Request streams around the feedback/ingress arbiter: two request inputs and one merged output.
// The master modport is the surrounding logic; the slave modport is the arbiter.
interface nukv_fb_arbiter_if #(
    parameter int DW = 224
);
    logic [DW-1:0] fb_in_data;
    logic          fb_in_valid;
    logic          fb_in_ready;
    logic [DW-1:0] reg_in_data;
    logic          reg_in_valid;
    logic          reg_in_ready;
    logic [DW-1:0] out_data;
    logic          out_is_fb;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output fb_in_data, fb_in_valid,
        input  fb_in_ready,
        output reg_in_data, reg_in_valid,
        input  reg_in_ready,
        input  out_data, out_is_fb, out_valid,
        output out_ready
    );

    modport slave (
        input  fb_in_data, fb_in_valid,
        output fb_in_ready,
        input  reg_in_data, reg_in_valid,
        output reg_in_ready,
        output out_data, out_is_fb, out_valid,
        input  out_ready
    );
endinterface

// File: rtl/nukv_fb_arbiter.sv
// Merges feedback and ingress requests into one pipeline stream. Feedback has priority,
// bounded by a burst limit, and ingress admission is capped by an in-flight credit count.
module nukv_fb_arbiter #(
    parameter int KEY_WIDTH    = 128,
    parameter int META_WIDTH   = 96,
    parameter int MAX_INFLIGHT = 8,
    parameter int FB_BURST     = 4,
    localparam int DW = KEY_WIDTH + META_WIDTH,
    localparam int W  = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    nukv_fb_arbiter_if.slave     bus,
    input  logic                 retire_valid_i,
    input  logic                 drain_req_i,
    output logic                 drained_o,
    output logic [W-1:0]         inflight_o,
    output logic                 err_underflow_o
);
    localparam int BW = $clog2(FB_BURST + 1);

    typedef enum logic [0:0] {
        ARB_FB  = 1'b0,
        ARB_REG = 1'b1
    } arb_state_e;

    arb_state_e    state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [W-1:0]  inflight_q, inflight_d;
    logic          err_q;
    logic          out_valid_q;
    logic          out_is_fb_q;
    logic [DW-1:0] out_data_q;

    logic          load_s;
    logic          retire_ok_s;
    logic          reg_elig_s;
    logic          grant_fb_s;
    logic          grant_reg_s;
    logic [BW-1:0] burst_inc_s;

    // A retire seen at full occupancy frees its credit for use in the same cycle.
    assign load_s      = !out_valid_q | bus.out_ready;
    assign retire_ok_s = retire_valid_i & (inflight_q != {W{1'b0}});
    assign reg_elig_s  = bus.reg_in_valid & !drain_req_i &
                         ((inflight_q < W'(MAX_INFLIGHT)) | retire_ok_s);
    assign burst_inc_s = burst_q + BW'(1);

    // Grant selection and next arbitration state.
    always_comb begin
        grant_fb_s  = 1'b0;
        grant_reg_s = 1'b0;
        state_d     = state_q;
        burst_d     = burst_q;
        if (rst || !load_s) begin
            state_d = state_q;
        end else if (state_q == ARB_REG && reg_elig_s) begin
            grant_reg_s = 1'b1;
            burst_d     = {BW{1'b0}};
            state_d     = ARB_FB;
        end else if (bus.fb_in_valid) begin
            grant_fb_s = 1'b1;
            if (reg_elig_s) begin
                burst_d = burst_inc_s;
                state_d = (burst_inc_s >= BW'(FB_BURST)) ? ARB_REG : ARB_FB;
            end else begin
                burst_d = {BW{1'b0}};
                state_d = ARB_FB;
            end
        end else if (reg_elig_s) begin
            grant_reg_s = 1'b1;
            burst_d     = {BW{1'b0}};
            state_d     = ARB_FB;
        end else begin
            state_d = state_q;
        end
    end

    // Credit count after this cycle's ingress grant and retire.
    always_comb begin
        inflight_d = inflight_q + W'(grant_reg_s) - W'(retire_ok_s);
    end

    // Arbiter state, credits, error flag and the single output entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_FB;
            burst_q     <= {BW{1'b0}};
            inflight_q  <= {W{1'b0}};
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_is_fb_q <= 1'b0;
            out_data_q  <= {DW{1'b0}};
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            inflight_q <= inflight_d;
            if (retire_valid_i && inflight_q == {W{1'b0}}) begin
                err_q <= 1'b1;
            end else begin
                err_q <= err_q;
            end
            if (load_s) begin
                out_valid_q <= grant_fb_s | grant_reg_s;
                out_is_fb_q <= grant_fb_s;
                if (grant_fb_s) begin
                    out_data_q <= bus.fb_in_data;
                end else if (grant_reg_s) begin
                    out_data_q <= bus.reg_in_data;
                end else begin
                    out_data_q <= out_data_q;
                end
            end else begin
                out_valid_q <= out_valid_q;
                out_is_fb_q <= out_is_fb_q;
                out_data_q  <= out_data_q;
            end
        end
    end

    assign bus.fb_in_ready  = grant_fb_s;
    assign bus.reg_in_ready = grant_reg_s;
    assign bus.out_data     = out_data_q;
    assign bus.out_is_fb    = out_is_fb_q;
    assign bus.out_valid    = out_valid_q;

    assign drained_o       = (inflight_q == {W{1'b0}}) & !out_valid_q & !bus.fb_in_valid;
    assign inflight_o      = inflight_q;
    assign err_underflow_o = err_q;
endmodule

// File: tb/tb_nukv_fb_arbiter.sv
// Bench for nukv_fb_arbiter: directed scenarios plus random traffic, all checked each
// cycle against a request-level model (credit count, feedback streak, held output entry).
module tb_nukv_fb_arbiter;
    localparam int K   = 128;
    localparam int M   = 96;
    localparam int MAX = 8;
    localparam int FBB = 4;
    localparam int DW  = K + M;
    localparam int W   = $clog2(MAX + 1);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         retire_valid = 1'b0;
    logic         drain_req = 1'b0;
    logic         drained;
    logic [W-1:0] inflight;
    logic         err_underflow;

    nukv_fb_arbiter_if #(.DW(DW)) bus ();

    nukv_fb_arbiter #(
        .KEY_WIDTH(K), .META_WIDTH(M), .MAX_INFLIGHT(MAX), .FB_BURST(FBB)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .retire_valid_i(retire_valid), .drain_req_i(drain_req),
        .drained_o(drained), .inflight_o(inflight), .err_underflow_o(err_underflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // model of the arbiter at request level
    int            m_inf = 0;
    int            m_streak = 0;
    bit            m_err = 0;
    bit            m_ov = 0;
    bit            m_isfb = 0;
    logic [DW-1:0] m_od = '0;

    bit last_fb, last_reg;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < 7; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic step(input bit r, input bit fv, input logic [DW-1:0] fd,
                        input bit rv, input logic [DW-1:0] rd,
                        input bit ordy, input bit ret, input bit drn);
        bit load, ret_ok, elig, g_fb, g_reg;
        @(negedge clk);
        rst = r;
        bus.fb_in_valid = fv;  bus.fb_in_data = fd;
        bus.reg_in_valid = rv; bus.reg_in_data = rd;
        bus.out_ready = ordy;
        retire_valid = ret;
        drain_req = drn;
        #1;
        load   = !m_ov || ordy;
        ret_ok = ret && (m_inf > 0);
        elig   = rv && !drn && ((m_inf < MAX) || ret_ok);
        g_fb = 0; g_reg = 0;
        if (!r && load) begin
            if (elig && (!fv || m_streak >= FBB)) g_reg = 1;
            else if (fv) g_fb = 1;
        end
        check("fb_in_ready", bus.fb_in_ready, g_fb);
        check("reg_in_ready", bus.reg_in_ready, g_reg);
        check("out_valid", bus.out_valid, m_ov);
        if (m_ov) check("out_data", bus.out_data, m_od);
        check("out_is_fb", bus.out_is_fb, m_isfb);
        check("inflight", inflight, m_inf);
        check("err_underflow", err_underflow, m_err);
        check("drained", drained, (m_inf == 0) && !m_ov && !fv);
        last_fb  = bus.fb_in_ready;
        last_reg = bus.reg_in_ready;
        @(posedge clk);
        if (r) begin
            m_inf = 0; m_streak = 0; m_err = 0; m_ov = 0; m_isfb = 0; m_od = '0;
        end else begin
            if (g_fb) m_streak = elig ? m_streak + 1 : 0;
            if (g_reg) m_streak = 0;
            if (load) begin
                m_ov = g_fb || g_reg;
                m_isfb = g_fb;
                if (g_fb) m_od = fd;
                else if (g_reg) m_od = rd;
            end
            if (ret && m_inf == 0) m_err = 1;
            m_inf = m_inf + int'(g_reg) - int'(ret_ok);
        end
    endtask

    task automatic idle(input bit ret, input bit drn);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, ret, drn);
    endtask

    initial begin
        int cnt_fb, cnt_reg;
        logic [9:0] pat;
        logic [DW-1:0] d0;

        bus.fb_in_valid = 1'b1; bus.reg_in_valid = 1'b1;
        bus.fb_in_data = '0; bus.reg_in_data = '0; bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // 1: reset with all valids high
        cnt_fb = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, rnd_data(), 1'b1, rnd_data(), 1'b1, 1'b1, 1'b0);
            cnt_fb += int'(last_fb) + int'(last_reg);
        end
        check("reset_readys", cnt_fb, 0);
        #1 bus.fb_in_valid = 1'b0;
        #1 check("reset_drained", drained, 1'b1);
        check("reset_out_valid", bus.out_valid, 1'b0);

        // 2: ingress only, credit cap
        cnt_reg = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, '0, 1'b1, rnd_data(), 1'b1, 1'b0, 1'b0);
            cnt_reg += int'(last_reg);
        end
        check("credit_cap_count", cnt_reg, 8);
        #1 check("credit_cap_inflight", inflight, 8);
        step(1'b0, 1'b0, '0, 1'b1, rnd_data(), 1'b1, 1'b1, 1'b0);
        check("retire_frees_credit", last_reg, 1'b1);
        #1 check("inflight_after_swap", inflight, 8);
        for (int i = 0; i < 8; i++) idle(1'b1, 1'b0);
        #1 check("inflight_cleared", inflight, 0);

        // 3: burst pattern FB x4 then REG
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, rnd_data(), 1'b1, rnd_data(), 1'b1, 1'b0, 1'b0);
            pat = {pat[8:0], last_fb};
        end
        check("burst_pattern", pat, 10'b1111011110);

        // 4: backpressure holds the entry
        d0 = rnd_data();
        step(1'b0, 1'b1, d0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cnt_fb = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, rnd_data(), 1'b1, rnd_data(), 1'b0, 1'b0, 1'b0);
            cnt_fb += int'(last_fb) + int'(last_reg);
            check("bp_data_stable", bus.out_data, d0);
        end
        check("bp_no_ready", cnt_fb, 0);
        step(1'b0, 1'b1, rnd_data(), 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("bp_release_grant", last_fb, 1'b1);

        // 5: drain with three credits in use
        for (int i = 0; i < 12 && m_inf > 0; i++) idle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, rnd_data(), 1'b1, 1'b0, 1'b0);
        #1 check("drain_inflight3", inflight, 3);
        cnt_fb = 0; cnt_reg = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, rnd_data(), 1'b1, rnd_data(), 1'b1, 1'b0, 1'b1);
            cnt_fb += int'(last_fb);
            cnt_reg += int'(last_reg);
        end
        check("drain_no_ingress", cnt_reg, 0);
        check("drain_fb_flows", cnt_fb, 8);
        for (int i = 0; i < 3; i++) idle(1'b1, 1'b1);
        idle(1'b0, 1'b1);
        #1 check("drained_after_retires", drained, 1'b1);

        // 6: underflow is ignored and sticky
        idle(1'b1, 1'b0);
        #1 check("underflow_inflight", inflight, 0);
        check("underflow_flag", err_underflow, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b0, 1'b0);
        #1 check("underflow_sticky", err_underflow, 1'b1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, rnd_data(),
                 $urandom_range(0, 9) < 6, rnd_data(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
        end

        step(1'b1, 1'b1, rnd_data(), 1'b1, rnd_data(), 1'b1, 1'b1, 1'b0);
        #1 check("final_reset_err", err_underflow, 1'b0);
        check("final_reset_inflight", inflight, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
